// File: rtl/sys_clk_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control word encodings and the sequencer state enum.
package sys_clk_pkg;

   localparam int DEFAULT_PERIOD = 49999;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CONTROL = 3'd1;
   localparam logic [2:0] REG_PERIODL = 3'd2;
   localparam logic [2:0] REG_PERIODH = 3'd3;
   localparam logic [2:0] REG_SNAPL   = 3'd4;
   localparam logic [2:0] REG_SNAPH   = 3'd5;

   localparam int CTRL_ITO_BIT   = 0;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_STOP_BIT  = 3;

   localparam logic [15:0] CTRL_RUN  = 16'h0007;
   localparam logic [15:0] CTRL_STOP = 16'h0008;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_RUN,
      ST_CLR_STAT,
      ST_WR_STOP,
      ST_SNAP_WR,
      ST_SNAP_RDL,
      ST_SNAP_RDH,
      ST_SNAP_CAP
   } state_t;

endpackage

// File: rtl/sys_clk_sequencer.sv
// Avalon-MM master that programs the interval timer for a periodic sample tick,
// services each timeout, and supports stop, reprogramming and counter snapshots.
module sys_clk_sequencer
   import sys_clk_pkg::*;
#(
   parameter int MIN_PERIOD = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      cfg_period,
   input  logic             cfg_go,
   input  logic             cfg_stop,
   input  logic             snap_req,
   output logic             ready,
   output logic             running,
   output logic             tick,
   output logic [CNT_W-1:0] tick_count,
   output logic             snap_valid,
   output logic [31:0]      snap_value,
   output logic [2:0]       tmr_address,
   output logic             tmr_chipselect,
   output logic             tmr_write_n,
   output logic [15:0]      tmr_writedata,
   input  logic [15:0]      tmr_readdata,
   input  logic             tmr_irq,
   output state_t           dbg_state
);

   // Request handshake: a pulse on cfg_go/cfg_stop/snap_req is taken only in a
   // cycle where ready=1; otherwise it is dropped. Priority stop > go > snap,
   // and a pending irq in RUN pre-empts every request.
   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_period;
   logic [31:0]      r_snap_value;
   logic [CNT_W-1:0] r_tick_count;
   logic             r_running;
   logic             r_ret_run;
   logic             w_take_go;
   logic             w_take_snap;
   logic             w_ready;
   logic [31:0]      w_clamped;

   assign w_clamped = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;

   always_comb begin
      w_next         = r_state;
      w_take_go      = 1'b0;
      w_take_snap    = 1'b0;
      w_ready        = 1'b0;
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_address    = REG_STATUS;
      tmr_writedata  = 16'h0000;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (cfg_go) begin
               w_take_go = 1'b1;
               w_next    = ST_WR_PL;
            end else if (snap_req) begin
               w_take_snap = 1'b1;
               w_next      = ST_SNAP_WR;
            end
         end
         ST_WR_PL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_PERIODL;
            tmr_writedata  = r_period[15:0];
            w_next         = ST_WR_PH;
         end
         ST_WR_PH: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_PERIODH;
            tmr_writedata  = r_period[31:16];
            w_next         = ST_WR_CTRL;
         end
         ST_WR_CTRL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_CONTROL;
            tmr_writedata  = CTRL_RUN;
            w_next         = ST_RUN;
         end
         ST_RUN: begin
            if (tmr_irq) begin
               w_next = ST_CLR_STAT;
            end else begin
               w_ready = 1'b1;
               if (cfg_stop) begin
                  w_next = ST_WR_STOP;
               end else if (cfg_go) begin
                  w_take_go = 1'b1;
                  w_next    = ST_WR_PL;
               end else if (snap_req) begin
                  w_take_snap = 1'b1;
                  w_next      = ST_SNAP_WR;
               end
            end
         end
         ST_CLR_STAT: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_STATUS;
            w_next         = ST_RUN;
         end
         ST_WR_STOP: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_CONTROL;
            tmr_writedata  = CTRL_STOP;
            w_next         = ST_IDLE;
         end
         ST_SNAP_WR: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_SNAPL;
            w_next         = ST_SNAP_RDL;
         end
         // Slave read data is registered, so each half lands one state later.
         ST_SNAP_RDL: begin
            tmr_chipselect = 1'b1;
            tmr_address    = REG_SNAPL;
            w_next         = ST_SNAP_RDH;
         end
         ST_SNAP_RDH: begin
            tmr_chipselect = 1'b1;
            tmr_address    = REG_SNAPH;
            w_next         = ST_SNAP_CAP;
         end
         ST_SNAP_CAP: begin
            w_next = r_ret_run ? ST_RUN : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_period     <= 32'd0;
         r_snap_value <= 32'd0;
         r_tick_count <= '0;
         r_running    <= 1'b0;
         r_ret_run    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take_go)
            r_period <= w_clamped;
         if (w_take_snap)
            r_ret_run <= (r_state == ST_RUN);
         if (r_state == ST_WR_CTRL)
            r_running <= 1'b1;
         if (r_state == ST_WR_STOP)
            r_running <= 1'b0;
         if (r_state == ST_CLR_STAT)
            r_tick_count <= r_tick_count + CNT_W'(1);
         if (r_state == ST_SNAP_RDH)
            r_snap_value[15:0] <= tmr_readdata;
         if (r_state == ST_SNAP_CAP)
            r_snap_value[31:16] <= tmr_readdata;
      end
   end

   // The upper half is forwarded during the valid pulse so the full value is
   // presented together with snap_valid.
   assign snap_value = (r_state == ST_SNAP_CAP) ? {tmr_readdata, r_snap_value[15:0]}
                                                : r_snap_value;
   assign snap_valid = (r_state == ST_SNAP_CAP);
   assign tick       = (r_state == ST_CLR_STAT);
   assign tick_count = r_tick_count;
   assign running    = r_running;
   assign ready      = w_ready;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_sys_clk_sequencer.sv
// Self-checking bench for sys_clk_sequencer with a behavioural interval-timer
// slave; expectations come from period/latency rules, not from the RTL.
module tb_sys_clk_sequencer;
   import sys_clk_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cfg_period = 32'd0;
   logic        cfg_go = 1'b0, cfg_stop = 1'b0, snap_req = 1'b0;
   logic        ready, running, tick, snap_valid;
   logic [15:0] tick_count;
   logic [31:0] snap_value;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect, tmr_write_n;
   logic [15:0] tmr_writedata;
   logic [15:0] tmr_readdata;
   logic        tmr_irq;
   state_t      dbg_state;

   sys_clk_sequencer #(.MIN_PERIOD(2), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_go(cfg_go),
      .cfg_stop(cfg_stop), .snap_req(snap_req), .ready(ready), .running(running),
      .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid),
      .snap_value(snap_value), .tmr_address(tmr_address),
      .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
      .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
      .tmr_irq(tmr_irq), .dbg_state(dbg_state)
   );

   // ---------------- behavioural interval timer slave ----------------
   logic [31:0] t_period, t_counter, t_snap;
   logic        t_run, t_to, t_ito, t_cont;
   assign tmr_irq = t_to & t_ito;

   always @(posedge clk) begin
      if (!reset_n) begin
         t_period <= 32'd49999; t_counter <= 32'd49999; t_snap <= 32'd0;
         t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
         tmr_readdata <= 16'd0;
      end else begin
         if (t_run) begin
            if (t_counter == 32'd0) begin
               t_to <= 1'b1;
               t_counter <= t_period;
               if (!t_cont) t_run <= 1'b0;
            end else begin
               t_counter <= t_counter - 32'd1;
            end
         end
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               3'd0: t_to <= 1'b0;
               3'd1: begin
                  t_ito  <= tmr_writedata[0];
                  t_cont <= tmr_writedata[1];
                  if (tmr_writedata[2]) begin t_run <= 1'b1; t_counter <= t_period; end
                  if (tmr_writedata[3]) t_run <= 1'b0;
               end
               3'd2: begin
                  t_period[15:0] <= tmr_writedata;
                  t_counter <= {t_period[31:16], tmr_writedata};
                  t_run <= 1'b0;
               end
               3'd3: begin
                  t_period[31:16] <= tmr_writedata;
                  t_counter <= {tmr_writedata, t_period[15:0]};
                  t_run <= 1'b0;
               end
               3'd4, 3'd5: t_snap <= t_counter;
               default: ;
            endcase
         end
         if (tmr_chipselect) begin
            case (tmr_address)
               3'd0: tmr_readdata <= {14'd0, t_run, t_to};
               3'd2: tmr_readdata <= t_period[15:0];
               3'd3: tmr_readdata <= t_period[31:16];
               3'd4: tmr_readdata <= t_snap[15:0];
               3'd5: tmr_readdata <= t_snap[31:16];
               default: tmr_readdata <= 16'd0;
            endcase
         end
      end
   end

   // ---------------- bus / tick monitor ----------------
   int          cyc = 0;
   logic [18:0] wr_q[$];
   int          wr_cyc[$];
   int          tick_cyc[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (reset_n) begin
         if (tmr_chipselect && !tmr_write_n) begin
            wr_q.push_back({tmr_address, tmr_writedata});
            wr_cyc.push_back(cyc);
         end
         if (tick) tick_cyc.push_back(cyc);
      end
   end

   // ---------------- scoreboard ----------------
   logic [18:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int tick_base = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   // kind: 0 = go, 1 = stop, 2 = snap. Returns the request cycle and the bus-log index.
   task automatic pulse_req(input int kind, input logic [31:0] p, output int g, output int rd);
      for (int i = 0; i < 2000 && !ready; i++) step(1);
      check("ready_wait", 32'(ready), 32'd1);
      rd = wr_q.size();
      g  = cyc;
      cfg_period = p;
      cfg_go   = (kind == 0);
      cfg_stop = (kind == 1);
      snap_req = (kind == 2);
      step(1);
      cfg_go = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
   endtask

   task automatic check_prog(input logic [31:0] p, input int g, input int rd);
      logic [31:0] pc;
      logic [18:0] e;
      pc = (p < 32'd2) ? 32'd2 : p;
      exp_q.push_back({3'd2, pc[15:0]});
      exp_q.push_back({3'd3, pc[31:16]});
      exp_q.push_back({3'd1, 16'h0007});
      check("prog_count", 32'(wr_q.size() - rd), 32'd3);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         if (rd + i < wr_q.size()) begin
            check("prog_write", 32'(wr_q[rd+i]), 32'(e));
            check("prog_cycle", 32'(wr_cyc[rd+i]), 32'(g + 1 + i));
         end
      end
   endtask

   task automatic wait_ticks(input int n, input int budget);
      int target;
      target = tick_cyc.size() + n;
      for (int i = 0; i < budget && tick_cyc.size() < target; i++) step(1);
      check("tick_wait", 32'(tick_cyc.size() >= target), 32'd1);
      step(1);
   endtask

   task automatic check_gaps(input int last_n, input int spacing);
      int sz;
      sz = tick_cyc.size();
      for (int i = sz - last_n; i < sz; i++)
         if (i >= 1) check("tick_gap", 32'(tick_cyc[i] - tick_cyc[i-1]), 32'(spacing));
   endtask

   task automatic check_count();
      check("tick_count", 32'(tick_count), 32'(16'(tick_cyc.size() - tick_base)));
   endtask

   task automatic check_bus_idle(input string tag);
      check(tag, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {11'd0, 1'b0, 1'b1, 3'd0, 16'd0});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g, rd, s, nb, base;
      logic [31:0] pr, pc, exp_snap;

      step(3);
      reset_n = 1'b1;
      tick_base = tick_cyc.size();

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         step(1);
         check_bus_idle("idle_bus");
         check("idle_ready", 32'(ready), 32'd1);
         check("idle_running", 32'(running), 32'd0);
         check("idle_tick", 32'(tick), 32'd0);
         check("idle_tick_count", 32'(tick_count), 32'd0);
      end
      check("idle_snap_value", snap_value, 32'd0);
      check("idle_snap_valid", 32'(snap_valid), 32'd0);

      // snapshot of the stopped timer after reset
      pulse_req(2, 32'd0, s, rd);
      for (int i = 0; i < 20 && !snap_valid; i++) step(1);
      check("snap_idle_latency", 32'(cyc - s), 32'd4);
      check("snap_idle_value", snap_value, 32'h0000C34F);
      step(1);
      check("snap_idle_pulse", 32'(snap_valid), 32'd0);
      check("snap_idle_hold", snap_value, 32'h0000C34F);
      check("snap_idle_ready", 32'(ready), 32'd1);

      // start with period 99
      pulse_req(0, 32'd99, g, rd);
      base = tick_cyc.size();
      step(3);
      check_prog(32'd99, g, rd);
      check("run_running", 32'(running), 32'd1);
      wait_ticks(5, 700);
      check("tick_count_5", 32'(tick_count), 32'd5);
      if (tick_cyc.size() >= base + 5) begin
         check("first_tick_delay", 32'(tick_cyc[base] - (g + 3)), 32'd102);
         check_gaps(4, 100);
      end

      // reprogram on the fly to period 9
      step($urandom_range(1, 60));
      nb = tick_cyc.size();
      pulse_req(0, 32'd9, g, rd);
      step(3);
      check_prog(32'd9, g, rd);
      wait_ticks(6, 300);
      for (int i = nb; i < tick_cyc.size(); i++)
         check("no_double_tick", 32'(tick_cyc[i] - tick_cyc[i-1] >= 10), 32'd1);
      check_gaps(4, 10);
      check_count();

      // stop right after a tick
      wait_ticks(1, 50);
      pulse_req(1, 32'd0, s, rd);
      step(1);
      check("stop_count", 32'(wr_q.size() - rd), 32'd1);
      if (wr_q.size() > rd) begin
         check("stop_write", 32'(wr_q[rd]), 32'({3'd1, 16'h0008}));
         check("stop_cycle", 32'(wr_cyc[rd]), 32'(s + 1));
      end
      check("stop_running", 32'(running), 32'd0);
      check("stop_ready", 32'(ready), 32'd1);
      nb = tick_cyc.size();
      step(200);
      check("stopped_no_tick", 32'(tick_cyc.size()), 32'(nb));
      check_count();

      // period 1 clamps to 2
      pulse_req(0, 32'd1, g, rd);
      base = tick_cyc.size();
      step(3);
      check_prog(32'd1, g, rd);
      wait_ticks(5, 100);
      if (tick_cyc.size() >= base + 5)
         check("first_tick_min", 32'(tick_cyc[base] - (g + 3)), 32'd5);
      check_gaps(4, 3);

      // irq in the same cycle as a go request
      for (int i = 0; i < 20 && !(tmr_irq && !tick); i++) step(1);
      check("irq_go_ready", 32'(ready), 32'd0);
      rd = wr_q.size();
      cfg_period = 32'd50;
      cfg_go = 1'b1;
      step(1);
      cfg_go = 1'b0;
      check("irq_go_tick", 32'(tick), 32'd1);
      check("irq_go_clr", {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {11'd0, 1'b1, 1'b0, 3'd0, 16'd0});
      step(6);
      for (int i = rd; i < wr_q.size(); i++)
         check("irq_go_dropped", 32'(wr_q[i]), 32'({3'd0, 16'h0000}));
      wait_ticks(2, 20);
      check_gaps(2, 3);

      // randomized periods
      for (int k = 0; k < 3; k++) begin
         pr = (k == 0) ? 32'd0 : 32'($urandom_range(1, 24));
         pc = (pr < 32'd2) ? 32'd2 : pr;
         pulse_req(0, pr, g, rd);
         step(3);
         check_prog(pr, g, rd);
         wait_ticks(5, 200);
         check_gaps(3, int'(pc) + 1);
         check_count();
      end

      // snapshot while running with a 17-bit period
      pulse_req(0, 32'h0001_0000, g, rd);
      step(3);
      check_prog(32'h0001_0000, g, rd);
      step($urandom_range(5, 400));
      pulse_req(2, 32'd0, s, rd);
      for (int i = 0; i < 20 && !snap_valid; i++) step(1);
      check("snap_run_latency", 32'(cyc - s), 32'd4);
      exp_snap = 32'h0001_0000 - 32'(s - g - 3);
      check("snap_run_value", snap_value, exp_snap);
      check("snap_run_hi", 32'(snap_value[31:16] <= 16'd1), 32'd1);
      step(1);
      check("snap_run_ready", 32'(ready), 32'd1);
      check("snap_run_running", 32'(running), 32'd1);

      // reset in the middle of reprogramming
      pulse_req(0, 32'd20, g, rd);
      step(1);
      check("wr_ph_bus", {11'd0, tmr_chipselect, tmr_write_n, tmr_address, 16'd0},
            {11'd0, 1'b1, 1'b0, 3'd3, 16'd0});
      reset_n = 1'b0;
      step(1);
      check_bus_idle("rst_bus");
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_running", 32'(running), 32'd0);
      check("rst_tick_count", 32'(tick_count), 32'd0);
      check("rst_snap_value", snap_value, 32'd0);
      reset_n = 1'b1;
      step(5);
      check_bus_idle("post_rst_bus");
      check("post_rst_tick", 32'(tick), 32'd0);

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
